bitstream_sweep_ctrl: RTL and testbench

Hardware sequencer for stochastic-bitstream characterisation. Steps a generator's 8-bit input value across a programmed range. For each point it clears the generator, waits a settle window, then counts ones on the activation output (relu/sigmoid) over a programmed bitstream length. It emits one (x, count) result per point over a valid/ready handshake, replacing the simulation-only sweep loop so activation transfer curves can be measured on silicon or FPGA.

---
 rtl/bitstream_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_bitstream_sweep_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_sweep_ctrl.sv
// Sweep sequencer for stochastic-bitstream characterisation: steps the generator x value
// over [x_start..x_end] (wrapping), counting activation ones for len cycles per point.
module bitstream_sweep_ctrl #(
    parameter int X_WIDTH = 8,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [X_WIDTH-1:0] x_start,
    input  logic [X_WIDTH-1:0] x_end,
    input  logic [15:0]        len,
    output logic               busy,
    output logic [X_WIDTH-1:0] gen_x,
    output logic               gen_clr,
    input  logic               dut_y,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [X_WIDTH-1:0] result_x,
    output logic [16:0]        result_count,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [X_WIDTH-1:0] cur_x_q, cur_x_d;
    logic [X_WIDTH-1:0] x_end_q, x_end_d;
    logic [16:0]        len_q, len_d;
    logic [16:0]        smp_q, smp_d;
    logic [16:0]        ones_q, ones_d;
    logic [3:0]         settle_q, settle_d;
    logic               done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        x_end_d  = x_end_q;
        len_d    = len_q;
        smp_d    = smp_q;
        ones_d   = ones_q;
        settle_d = settle_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_x_d = x_start;
                    x_end_d = x_end;
                    // len==0 stands for a full 65536-sample bitstream
                    len_d   = (len == 16'd0) ? 17'h10000 : {1'b0, len};
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                smp_d    = '0;
                ones_d   = '0;
                settle_d = '0;
                state_d  = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                smp_d  = smp_q + 17'd1;
                ones_d = ones_q + {16'd0, dut_y};
                if (smp_d == len_q) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (result_ready) begin
                    if (cur_x_q == x_end_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cur_x_d = cur_x_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cur_x_q  <= '0;
            x_end_q  <= '0;
            len_q    <= '0;
            smp_q    <= '0;
            ones_q   <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            x_end_q  <= x_end_d;
            len_q    <= len_d;
            smp_q    <= smp_d;
            ones_q   <= ones_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign gen_clr      = (state_q == ST_LOAD);
    assign result_valid = (state_q == ST_HOLD);
    assign gen_x        = cur_x_q;
    assign result_x     = cur_x_q;
    assign result_count = ones_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bitstream_sweep_ctrl.sv
// Bench for bitstream_sweep_ctrl: directed sweeps with random activation/ready stimulus
// checked cycle by cycle against a timeline model built from the sweep timing rules.
module tb_bitstream_sweep_ctrl;

    localparam int XW = 8;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] x_start;
    logic [XW-1:0] x_end;
    logic [15:0]   len;
    logic          busy;
    logic [XW-1:0] gen_x;
    logic          gen_clr;
    logic          dut_y;
    logic          result_valid;
    logic          result_ready;
    logic [XW-1:0] result_x;
    logic [16:0]   result_count;
    logic          done;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    bit tog    = 1'b1;

    always #5 clk = ~clk;

    bitstream_sweep_ctrl #(.X_WIDTH(XW), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .start(start), .x_start(x_start), .x_end(x_end), .len(len),
        .busy(busy), .gen_x(gen_x), .gen_clr(gen_clr), .dut_y(dut_y),
        .result_valid(result_valid), .result_ready(result_ready), .result_x(result_x),
        .result_count(result_count), .done(done)
    );

    // After tick(), outputs belong to cycle index edges+1 (the cycle ending at the next edge).
    task automatic tick();
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_gen_x"}, gen_x, 0);
        chk({tag, "_gen_clr"}, gen_clr, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_rx"}, result_x, 0);
        chk({tag, "_rcount"}, result_count, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode: 0 random dut_y, 1 constant one, 2 one only inside the counting window, 3 toggling
    task automatic run_sweep(input int xs, input int xe, input int ln, input int mode,
                             input int rdly, input int glitch_off, input int rst_pt,
                             output int first_valid, output int start_cyc);
        int L, npts, ld, vst, c, exp_x, exp_cnt, pt, clr_seen, budget;
        bit fin, inv, rdy, y, in_run;
        L = (ln == 0) ? 65536 : ln;
        npts = ((xe - xs) & 255) + 1;
        first_valid = -1;
        c = edges + 1;
        start_cyc = c;
        start = 1'b1;
        x_start = 8'(xs);
        x_end = 8'(xe);
        len = 16'(ln);
        dut_y = 1'($urandom);
        result_ready = 1'($urandom);
        tick();
        start = 1'b0;
        x_start = 8'($urandom);
        x_end = 8'($urandom);
        len = 16'($urandom);
        ld = c + 1;
        vst = ld + 1 + ST + L;
        exp_x = xs & 255;
        exp_cnt = 0;
        pt = 0;
        fin = 1'b0;
        clr_seen = 0;
        budget = 0;
        while (!fin) begin
            c = edges + 1;
            inv = (c >= vst);
            if (gen_clr) clr_seen++;
            if (result_valid && first_valid < 0) first_valid = c;
            chk("gen_clr", gen_clr, (c == ld));
            chk("busy", busy, 1);
            chk("valid", result_valid, inv);
            chk("gen_x", gen_x, exp_x);
            chk("done_low", done, 0);
            if (inv) begin
                chk("result_x", result_x, exp_x);
                chk("result_count", result_count, exp_cnt);
            end
            in_run = (c >= ld + 1 + ST) && (c <= ld + ST + L);
            case (mode)
                0: y = 1'($urandom);
                1: y = 1'b1;
                2: y = in_run;
                default: y = tog;
            endcase
            tog = ~tog;
            dut_y = y;
            if (in_run && y) exp_cnt++;
            rdy = inv ? (c >= vst + rdly) : 1'($urandom);
            result_ready = rdy;
            start = (glitch_off > 0) && (c == start_cyc + glitch_off);
            if (rst_pt == pt && c == ld + ST + 2) begin
                rst = 1'b1;
                start = 1'b1;
                tick();
                rst = 1'b0;
                start = 1'b0;
                chk_reset("rst_mid");
                tick();
                chk("rst_start_ignored", busy, 0);
                chk("rst_no_valid", result_valid, 0);
                return;
            end
            tick();
            if (inv && rdy) begin
                if (exp_x == (xe & 255)) begin
                    fin = 1'b1;
                end else begin
                    exp_x = (exp_x + 1) & 255;
                    ld = c + 1;
                    vst = ld + 1 + ST + L;
                    exp_cnt = 0;
                    pt++;
                end
            end
            budget++;
            if (budget > 80000) begin
                checks++;
                errors++;
                $error("FAIL timeout sweep did not finish observed_cycles=%0d", budget);
                return;
            end
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", result_valid, 0);
        chk("done_clr", gen_clr, 0);
        chk("idle_gen_x", gen_x, xe & 255);
        chk("clr_count", clr_seen, npts);
        tick();
        chk("done_single", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int fv, sc, xs, span, ln;
        rst = 1'b1;
        start = 1'b0;
        x_start = '0;
        x_end = '0;
        len = '0;
        dut_y = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();
        chk_reset("por");
        rst = 1'b0;
        tick();
        chk("por_idle", busy, 0);

        // single point, constant ones, valid 2+SETTLE+L cycles after the start cycle
        run_sweep(5, 5, 100, 1, 0, 0, -1, fv, sc);
        chk("latency", fv - sc, 2 + ST + 100);

        // len=0 means 65536 samples; settle/load samples excluded
        run_sweep(9, 9, 0, 2, 0, 0, -1, fv, sc);

        // wrap-around sweep 254,255,0,1 with toggling input
        run_sweep(254, 1, 8, 3, 0, 0, -1, fv, sc);

        // back-pressure: ready held low 50 cycles in each HOLD
        run_sweep(10, 12, 20, 0, 50, 0, -1, fv, sc);

        // reset in the middle of the second point, then a fresh sweep
        run_sweep(30, 35, 16, 0, 0, 0, 1, fv, sc);
        run_sweep(30, 32, 16, 0, 2, 0, -1, fv, sc);

        // start pulsed while busy must be ignored
        run_sweep(100, 103, 12, 0, 1, 30, -1, fv, sc);

        // length-1 boundary
        run_sweep(255, 0, 1, 0, 0, 0, -1, fv, sc);

        for (int i = 0; i < 4; i++) begin
            xs = $urandom_range(255);
            span = $urandom_range(3);
            ln = $urandom_range(40, 1);
            run_sweep(xs, (xs + span) & 255, ln, 0, $urandom_range(5), 0, -1, fv, sc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
